// File: rtl/modn_updown_counter.sv
// modn_updown_counter
//
// Parameterised modulo-N up/down counter intended for timebase dividers and
// cascaded modulo/BCD chains. In a chain, the tc of one stage drives the en of the next.
//
// Parameters:
//   width   - counter width in bits (1..31)
//   modulus - count range is 0..modulus-1. Legal range is 2..2**width.
//
// Ports:
//   clk      in   single clock, rising-edge
//   rst      in   synchronous active-high reset
//   en       in   count enable; count holds when low
//   updown   in   direction, 1 = up, 0 = down
//   sat      in   (only with UDCNT_SAT_EN) saturate at the terminal value instead of wrapping
//   load     in   parallel load strobe; has priority over en
//   load_val in   value to load; clamped to modulus-1 when out of range
//   count    out  registered counter value, always < modulus
//   tc       out  combinational terminal count for the current direction, gated by en
//   wrap     out  registered one-cycle pulse, set alongside a count that wrapped
//   load_err out  registered one-cycle pulse, set alongside a clamped load
//
// Configuration:
//   UDCNT_SAT_EN - when defined, adds the sat input after updown.

module modn_updown_counter #(
  parameter int unsigned width   = 8,
  parameter int unsigned modulus = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             updown,
`ifdef UDCNT_SAT_EN
  input  logic             sat,
`endif
  input  logic             load,
  input  logic [width-1:0] load_val,
  output logic [width-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Elaboration-time parameter checks.
  if ((width < 1) || (width > 31)) begin : g_bad_width
    $error("modn_updown_counter: width must be in 1..31");
  end
  if ((modulus < 2) || (64'(modulus) > (64'(1) << width))) begin : g_bad_modulus
    $error("modn_updown_counter: modulus must be in 2..2**width");
  end

  // Compare at width+1 bits so that modulus == 2**width is representable.
  localparam logic [width:0]   ModExt  = (width + 1)'(modulus);
  localparam logic [width:0]   LastExt = (width + 1)'(modulus - 1);
  localparam logic [width-1:0] LastVal = width'(modulus - 1);

  logic [width-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic at_last;
  logic at_zero;
  logic load_ok;
  logic sat_hold;

  assign at_last = ({1'b0, count_q} == LastExt);
  assign at_zero = (count_q == '0);
  assign load_ok = ({1'b0, load_val} < ModExt);

`ifdef UDCNT_SAT_EN
  assign sat_hold = sat;
`else
  assign sat_hold = 1'b0;
`endif

  // tc flags the cycle whose edge would wrap (or saturate) in the current direction.
  assign tc = en & ((updown & at_last) | (~updown & at_zero));

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        count_d    = LastVal;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (updown) begin
        if (at_last) begin
          if (!sat_hold) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + width'(1);
        end
      end else begin
        if (at_zero) begin
          if (!sat_hold) begin
            count_d = LastVal;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - width'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Testbench for modn_updown_counter: two instances (modulus 10 and modulus 16, width 4)
// share stimulus. A driver applies inputs on the falling edge, steps an arithmetic
// reference model and queues the expected post-edge outputs; a monitor pops and
// compares just after each rising edge.

module tb_modn_updown_counter;

`ifdef UDCNT_SAT_EN
  localparam bit HasSat = 1'b1;
`else
  localparam bit HasSat = 1'b0;
`endif

  localparam int ModA = 10;
  localparam int ModB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       updown = 1'b1;
  logic       sat_s = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, wrap_a, wrap_b, lerr_a, lerr_b;

  always #5 clk = ~clk;

  modn_updown_counter #(.width(4), .modulus(ModA)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .updown   (updown),
`ifdef UDCNT_SAT_EN
    .sat      (sat_s),
`endif
    .load     (load),
    .load_val (load_val),
    .count    (count_a),
    .tc       (tc_a),
    .wrap     (wrap_a),
    .load_err (lerr_a)
  );

  modn_updown_counter #(.width(4), .modulus(ModB)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .updown   (updown),
`ifdef UDCNT_SAT_EN
    .sat      (sat_s),
`endif
    .load     (load),
    .load_val (load_val),
    .count    (count_b),
    .tc       (tc_b),
    .wrap     (wrap_b),
    .load_err (lerr_b)
  );

  typedef struct {
    int ca; int wa; int la;
    int cb; int wb; int lb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ma = 0;
  int   mb = 0;
  bit   known = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input int expv);
    checks++;
    if (act !== 8'(expv)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference behaviour in plain modular arithmetic.
  function automatic void model(input int m, input int c, input bit r, input bit l,
                                input int lv, input bit e, input bit u, input bit s,
                                output int nc, output int nw, output int nl);
    nc = c; nw = 0; nl = 0;
    if (r) begin
      nc = 0;
    end else if (l) begin
      if (lv < m) nc = lv;
      else begin
        nc = m - 1;
        nl = 1;
      end
    end else if (e) begin
      if (u) begin
        if (c + 1 == m) begin
          if (!s) begin nc = 0; nw = 1; end
        end else nc = c + 1;
      end else begin
        if (c == 0) begin
          if (!s) begin nc = m - 1; nw = 1; end
        end else nc = c - 1;
      end
    end
  endfunction

  function automatic int tc_model(input int m, input int c, input bit e, input bit u);
    return (e && ((u && c == m - 1) || (!u && c == 0))) ? 1 : 0;
  endfunction

  task automatic drive(input bit r, input bit l, input int lv, input bit e, input bit u,
                       input bit s);
    exp_t x;
    bit   se;
    @(negedge clk);
    rst = r; load = l; load_val = 4'(lv); en = e; updown = u; sat_s = s;
    se = s & HasSat;
    #1;
    if (known) begin
      chk("tc_a", {7'd0, tc_a}, tc_model(ModA, ma, e, u));
      chk("tc_b", {7'd0, tc_b}, tc_model(ModB, mb, e, u));
    end
    if (r || known) begin
      model(ModA, ma, r, l, lv, e, u, se, x.ca, x.wa, x.la);
      model(ModB, mb, r, l, lv, e, u, se, x.cb, x.wb, x.lb);
      ma = x.ca;
      mb = x.cb;
      known = 1'b1;
      exp_q.push_back(x);
    end
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count_a", {4'd0, count_a}, x.ca);
        chk("wrap_a",  {7'd0, wrap_a},  x.wa);
        chk("lerr_a",  {7'd0, lerr_a},  x.la);
        chk("count_b", {4'd0, count_b}, x.cb);
        chk("wrap_b",  {7'd0, wrap_b},  x.wb);
        chk("lerr_b",  {7'd0, lerr_b},  x.lb);
      end
    end
  end

  initial begin
    // Count up through a wrap, then count down from reset.
    drive(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);
    // Loads: in range, then out of range (clamps on the modulus-10 instance).
    drive(0, 1, 7, 0, 1, 0);
    drive(0, 1, 13, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    // Reset and load both override a terminal-value count.
    drive(0, 1, 9, 0, 1, 0);
    drive(1, 0, 0, 1, 1, 0);
    drive(0, 1, 9, 0, 1, 0);
    drive(0, 1, 4, 1, 1, 0);
    // Natural binary overflow on the modulus-16 instance, then hold.
    drive(0, 1, 14, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    // Saturation: holds at the terminal value with sat, wraps once sat drops.
    drive(0, 1, 8, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 0, 1);
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
    end
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
